pipe_alu: RTL and testbench

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/pipe_alu.sv | 132 +++++++++++++
 tb/tb_pipe_alu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu.sv
// Pipelined ALU with a one-deep result register and a ready/valid handshake on both sides.
// Define PIPE_ALU_MUL_EN to build the multi-cycle shift-add multiplier; otherwise op 110 returns zero.
module pipe_alu #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             busy
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_ACC = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    logic [WIDTH-1:0] acc, acc_nxt, res_y;
    logic             res_c;
    logic             fire, slot_free;

    assign slot_free = !out_valid || out_ready;
    assign fire      = in_valid && in_ready;

    // Single-cycle results; MUL lands in the default arm and yields zero when the multiplier is absent.
    always_comb begin
        res_y   = '0;
        res_c   = 1'b0;
        acc_nxt = acc;
        unique case (op)
            OP_ADD: {res_c, res_y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                res_y = a - b;
                res_c = (a < b);
            end
            OP_AND: res_y = a & b;
            OP_OR:  res_y = a | b;
            OP_XOR: res_y = a ^ b;
            OP_ACC: begin
                {res_c, acc_nxt} = {1'b0, acc} + {1'b0, a};
                res_y = acc_nxt;
            end
            OP_CLR: begin
                acc_nxt = ACC_INIT;
                res_y   = ACC_INIT;
            end
            default: ;
        endcase
    end

`ifdef PIPE_ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
    assign in_ready = (state == S_IDLE) && slot_free;
    assign busy     = (state == S_MUL);
`else
    assign in_ready = slot_free;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            acc       <= ACC_INIT;
`ifdef PIPE_ALU_MUL_EN
            state     <= S_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
`endif
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
            if (fire && op == OP_MUL) begin
                state  <= S_MUL;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                cnt    <= '0;
            end else
`endif
            if (fire) begin
                out_valid <= 1'b1;
                y         <= res_y;
                carry     <= res_c;
                zero      <= (res_y == '0);
                acc       <= acc_nxt;
            end
`ifdef PIPE_ALU_MUL_EN
            // One partial product per cycle; the last step writes the result directly.
            if (state == S_MUL) begin
                prod   <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b1;
                    y         <= prod_nxt[WIDTH-1:0];
                    carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
                    zero      <= (prod_nxt[WIDTH-1:0] == '0);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: directed corner cases, then randomized traffic with random backpressure.
module tb_pipe_alu;
    localparam int         W  = 8;
    localparam logic [W-1:0] AI = 8'h00;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, ACC = 3'd5, MUL = 3'd6, CLR = 3'd7;

    logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, carry, zero, busy;
    logic [W-1:0] y;

    pipe_alu #(.WIDTH(W), .ACC_INIT(AI)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] y; logic c; } exp_t;
    exp_t q[$];
    int   checks = 0, passes = 0;
    int   macc = int'(AI);
    bit   rnd = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic on the opcode's definition.
    function automatic exp_t model(input logic [2:0] o, input int x, input int z);
        int   mask = (1 << W) - 1;
        int   s;
        exp_t e;
        e.c = 1'b0;
        e.y = '0;
        case (o)
            ADD:  begin s = x + z; e.y = W'(s & mask); e.c = 1'((s >> W) & 1); end
            SUB:  begin e.y = W'((x - z) & mask); e.c = (x < z); end
            AND_: e.y = W'(x & z);
            OR_:  e.y = W'(x | z);
            XOR_: e.y = W'(x ^ z);
            ACC:  begin s = macc + x; macc = s & mask; e.y = W'(macc); e.c = 1'((s >> W) & 1); end
`ifdef PIPE_ALU_MUL_EN
            MUL:  begin s = x * z; e.y = W'(s & mask); e.c = ((s >> W) != 0); end
`endif
            CLR:  begin macc = int'(AI); e.y = AI; end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: every consumed result must match the oldest outstanding expectation.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got y=0x%0h, required no result", y);
            end else begin
                me = q.pop_front();
                chk("sb_y", int'(y), int'(me.y));
                chk("sb_carry", int'(carry), int'(me.c));
                chk("sb_zero", int'(zero), int'(me.y == '0));
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        int n = 0;
        in_valid = 1'b1; op = o; a = x; b = z;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        if (in_ready) q.push_back(model(o, int'(x), int'(z)));
        else begin
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        step();

        send(ADD, 8'hF0, 8'h20);
        chk("add_y", int'(y), 8'h10); chk("add_carry", int'(carry), 1);
        chk("add_zero", int'(zero), 0); chk("add_valid", int'(out_valid), 1);
        send(SUB, 8'h05, 8'h05);
        chk("sub_eq_y", int'(y), 0); chk("sub_eq_zero", int'(zero), 1); chk("sub_eq_carry", int'(carry), 0);
        send(SUB, 8'h03, 8'h05);
        chk("sub_borrow_y", int'(y), 8'hFE); chk("sub_borrow_carry", int'(carry), 1);

        send(CLR, 8'h55, 8'h55);
        send(ACC, 8'h80, 8'h13);
        chk("acc1_y", int'(y), 8'h80); chk("acc1_carry", int'(carry), 0);
        send(ACC, 8'h80, 8'h00);
        chk("acc2_y", int'(y), 0); chk("acc2_carry", int'(carry), 1); chk("acc2_zero", int'(zero), 1);

        send(MUL, 8'h10, 8'h11);
`ifdef PIPE_ALU_MUL_EN
        for (int i = 0; i < W; i++) begin
            chk("mul_busy", int'(busy), 1);
            chk("mul_in_ready", int'(in_ready), 0);
            chk("mul_no_valid", int'(out_valid), 0);
            step();
        end
        chk("mul_done_busy", int'(busy), 0);
        chk("mul_y", int'(y), 8'h10); chk("mul_carry", int'(carry), 1);
        chk("mul_valid", int'(out_valid), 1);
`else
        chk("mul_off_y", int'(y), 0); chk("mul_off_carry", int'(carry), 0);
        chk("mul_off_zero", int'(zero), 1); chk("mul_off_busy", int'(busy), 0);
`endif

        step();
        out_ready = 1'b0;
        send(ADD, 8'h33, 8'h44);
        for (int i = 0; i < 5; i++) begin
            chk("hold_y", int'(y), 8'h77);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        send(XOR_, 8'h0F, 8'hFF);
        chk("b2b_y", int'(y), 8'hF0); chk("b2b_valid", int'(out_valid), 1);

        send(ACC, 8'h05, 8'h00);
`ifdef PIPE_ALU_MUL_EN
        send(MUL, 8'h0F, 8'h0F);
        repeat (3) step();
`else
        step();
        out_ready = 1'b0;
        send(ADD, 8'h01, 8'h02);
        step();
`endif
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_zero", int'(zero), 1);
        q.delete();
        macc = int'(AI);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", int'(in_ready), 1);
        repeat (12) step();
        send(ACC, 8'h00, 8'h00);
        chk("acc_after_reset", int'(y), int'(AI));

        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            if ($urandom_range(0, 4) == 0) step();
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
